// File: rtl/time_calendar_core.sv
// rtl/time_calendar_core.sv - 1 s prescaler, 24 h clock and 2000-2099 calendar with ASCII digit outputs
module time_calendar_core #(
    parameter int TICK_DIV = 50000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [5:0] MODE,
    input  logic       UP,
    input  logic       DOWN,
    output logic [7:0] H10,
    output logic [7:0] H1,
    output logic [7:0] M10,
    output logic [7:0] M1,
    output logic [7:0] S10,
    output logic [7:0] S1,
    output logic [7:0] Y10,
    output logic [7:0] Y1,
    output logic [7:0] MT10,
    output logic [7:0] MT1,
    output logic [7:0] D10,
    output logic [7:0] D1,
    output logic       SEC_TICK
);

    localparam int PW = 20;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        SEL_NONE, SEL_HOUR, SEL_MIN, SEL_SEC, SEL_YEAR, SEL_MON, SEL_DAY
    } sel_t;

    logic [PW-1:0] pcnt, pcnt_n;
    logic [4:0]    hour, hour_n;
    logic [5:0]    minute, minute_n;
    logic [5:0]    second, second_n;
    logic [6:0]    year, year_n;
    logic [3:0]    month, month_n;
    logic [4:0]    day, day_n;
    logic [4:0]    dim_cur, dim_new;
    sel_t          sel;
    logic          set_mode, tick, step_up, step_dn;

    function automatic logic [4:0] days_in(input logic [3:0] m, input logic [6:0] y);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: days_in = 5'd30;
            4'd2:                    days_in = (y[1:0] == 2'd0) ? 5'd29 : 5'd28;
            default:                 days_in = 5'd31;
        endcase
    endfunction

    function automatic logic [15:0] to_ascii(input logic [6:0] v);
        logic [6:0] tens, units;
        tens     = v / 7'd10;
        units    = v % 7'd10;
        to_ascii = {8'h30 + {1'b0, tens}, 8'h30 + {1'b0, units}};
    endfunction

    always_comb begin
        case (MODE)
            6'b010011: sel = SEL_HOUR;
            6'b010101: sel = SEL_MIN;
            6'b010111: sel = SEL_SEC;
            6'b011011: sel = SEL_YEAR;
            6'b011101: sel = SEL_MON;
            6'b011111: sel = SEL_DAY;
            default:   sel = SEL_NONE;
        endcase
    end

    assign set_mode = (sel != SEL_NONE);
    assign tick     = !set_mode && (pcnt == PMAX);
    assign step_up  = set_mode && UP && !DOWN;
    assign step_dn  = set_mode && DOWN && !UP;
    assign dim_cur  = days_in(month, year);

    always_comb begin
        pcnt_n   = pcnt;
        hour_n   = hour;
        minute_n = minute;
        second_n = second;
        year_n   = year;
        month_n  = month;
        day_n    = day;
        if (set_mode) begin
            pcnt_n = '0;
            if (step_up || step_dn) begin
                case (sel)
                    SEL_HOUR: hour_n   = step_up ? ((hour == 5'd23) ? 5'd0 : hour + 5'd1)
                                                 : ((hour == 5'd0) ? 5'd23 : hour - 5'd1);
                    SEL_MIN:  minute_n = step_up ? ((minute == 6'd59) ? 6'd0 : minute + 6'd1)
                                                 : ((minute == 6'd0) ? 6'd59 : minute - 6'd1);
                    SEL_SEC:  second_n = step_up ? ((second == 6'd59) ? 6'd0 : second + 6'd1)
                                                 : ((second == 6'd0) ? 6'd59 : second - 6'd1);
                    SEL_YEAR: year_n   = step_up ? ((year == 7'd99) ? 7'd0 : year + 7'd1)
                                                 : ((year == 7'd0) ? 7'd99 : year - 7'd1);
                    SEL_MON:  month_n  = step_up ? ((month == 4'd12) ? 4'd1 : month + 4'd1)
                                                 : ((month == 4'd1) ? 4'd12 : month - 4'd1);
                    SEL_DAY:  day_n    = step_up ? ((day == dim_cur) ? 5'd1 : day + 5'd1)
                                                 : ((day == 5'd1) ? dim_cur : day - 5'd1);
                    default:  ;
                endcase
            end
        end else if (tick) begin
            pcnt_n = '0;
            if (second != 6'd59) second_n = second + 6'd1;
            else begin
                second_n = 6'd0;
                if (minute != 6'd59) minute_n = minute + 6'd1;
                else begin
                    minute_n = 6'd0;
                    if (hour != 5'd23) hour_n = hour + 5'd1;
                    else begin
                        hour_n = 5'd0;
                        if (day != dim_cur) day_n = day + 5'd1;
                        else begin
                            day_n = 5'd1;
                            if (month != 4'd12) month_n = month + 4'd1;
                            else begin
                                month_n = 4'd1;
                                year_n  = (year == 7'd99) ? 7'd0 : year + 7'd1;
                            end
                        end
                    end
                end
            end
        end else begin
            pcnt_n = pcnt + 1'b1;
        end
        // A month or year edit can leave the day past the new month's end.
        dim_new = days_in(month_n, year_n);
        if (day_n > dim_new) day_n = dim_new;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pcnt     <= '0;
            hour     <= 5'd0;
            minute   <= 6'd0;
            second   <= 6'd0;
            year     <= 7'd0;
            month    <= 4'd1;
            day      <= 5'd1;
            SEC_TICK <= 1'b0;
        end else begin
            pcnt     <= pcnt_n;
            hour     <= hour_n;
            minute   <= minute_n;
            second   <= second_n;
            year     <= year_n;
            month    <= month_n;
            day      <= day_n;
            SEC_TICK <= tick;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            {H10, H1}   <= 16'h3030;
            {M10, M1}   <= 16'h3030;
            {S10, S1}   <= 16'h3030;
            {Y10, Y1}   <= 16'h3030;
            {MT10, MT1} <= 16'h3031;
            {D10, D1}   <= 16'h3031;
        end else begin
            {H10, H1}   <= to_ascii({2'b0, hour});
            {M10, M1}   <= to_ascii({1'b0, minute});
            {S10, S1}   <= to_ascii({1'b0, second});
            {Y10, Y1}   <= to_ascii(year);
            {MT10, MT1} <= to_ascii({3'b0, month});
            {D10, D1}   <= to_ascii({2'b0, day});
        end
    end

endmodule

// File: tb/tb_time_calendar_core.sv
// tb/tb_time_calendar_core.sv - directed self-checking bench for time_calendar_core
module tb_time_calendar_core;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [5:0] MODE = 6'b000000;
    logic       UP = 1'b0;
    logic       DOWN = 1'b0;
    logic [7:0] H10, H1, M10, M1, S10, S1, Y10, Y1, MT10, MT1, D10, D1;
    logic       SEC_TICK;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] M_RUN  = 6'b000000;
    localparam logic [5:0] M_HOUR = 6'b010011;
    localparam logic [5:0] M_MIN  = 6'b010101;
    localparam logic [5:0] M_SEC  = 6'b010111;
    localparam logic [5:0] M_YEAR = 6'b011011;
    localparam logic [5:0] M_MON  = 6'b011101;
    localparam logic [5:0] M_DAY  = 6'b011111;

    time_calendar_core #(.TICK_DIV(4)) dut (
        .CLK(CLK), .RESET(RESET), .MODE(MODE), .UP(UP), .DOWN(DOWN),
        .H10(H10), .H1(H1), .M10(M10), .M1(M1), .S10(S10), .S1(S1),
        .Y10(Y10), .Y1(Y1), .MT10(MT10), .MT1(MT1), .D10(D10), .D1(D1),
        .SEC_TICK(SEC_TICK)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_field(input string tag, input logic [7:0] t, input logic [7:0] u, input int v);
        chk({tag, "10"}, t, 8'(8'h30 + v / 10));
        chk({tag, "1"},  u, 8'(8'h30 + v % 10));
    endtask

    task automatic check_all(input int h, input int m, input int s, input int y, input int mo, input int d);
        chk_field("H", H10, H1, h);
        chk_field("M", M10, M1, m);
        chk_field("S", S10, S1, s);
        chk_field("Y", Y10, Y1, y);
        chk_field("MT", MT10, MT1, mo);
        chk_field("D", D10, D1, d);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        MODE  = M_RUN;
        UP    = 1'b0;
        DOWN  = 1'b0;
        step(2);
        RESET = 1'b0;
    endtask

    task automatic pulse(input logic [5:0] mode, input logic up, input logic dn, input int width);
        MODE = mode;
        UP   = up;
        DOWN = dn;
        step(width);
        UP   = 1'b0;
        DOWN = 1'b0;
    endtask

    task automatic set_235959();
        pulse(M_HOUR, 1'b0, 1'b1, 1);
        pulse(M_MIN,  1'b0, 1'b1, 1);
        pulse(M_SEC,  1'b0, 1'b1, 1);
    endtask

    initial begin
        int tick_seen;

        // Reset values and free-running seconds
        do_reset();
        chk("rst_tick", {7'b0, SEC_TICK}, 8'h00);
        check_all(0, 0, 0, 0, 1, 1);
        for (int k = 1; k <= 13; k++) begin
            step(1);
            if (k <= 12) chk("run_tick", {7'b0, SEC_TICK}, (k % 4 == 0) ? 8'h01 : 8'h00);
            chk("run_S1", S1, 8'(8'h30 + (k - 1) / 4));
        end
        check_all(0, 0, 3, 0, 1, 1);

        // Full rollover 99-12-31 23:59:59 -> 00-01-01 00:00:00
        do_reset();
        set_235959();
        pulse(M_YEAR, 1'b0, 1'b1, 1);
        pulse(M_MON,  1'b0, 1'b1, 1);
        pulse(M_DAY,  1'b0, 1'b1, 1);
        MODE = M_RUN;
        step(1);
        check_all(23, 59, 59, 99, 12, 31);
        step(3);
        chk("roll_tick", {7'b0, SEC_TICK}, 8'h01);
        step(1);
        check_all(0, 0, 0, 0, 1, 1);

        // Leap year 04: Feb 28 rolls to Feb 29 (year pulse 4 cycles wide)
        do_reset();
        pulse(M_YEAR, 1'b1, 1'b0, 4);
        pulse(M_MON,  1'b1, 1'b0, 1);
        pulse(M_DAY,  1'b0, 1'b1, 2);
        set_235959();
        MODE = M_RUN;
        step(1);
        check_all(23, 59, 59, 4, 2, 28);
        step(4);
        check_all(0, 0, 0, 4, 2, 29);

        // Non-leap year 05: Feb 28 rolls to Mar 01
        do_reset();
        pulse(M_YEAR, 1'b1, 1'b0, 5);
        pulse(M_MON,  1'b1, 1'b0, 1);
        pulse(M_DAY,  1'b0, 1'b1, 1);
        set_235959();
        MODE = M_RUN;
        step(1);
        check_all(23, 59, 59, 5, 2, 28);
        step(4);
        check_all(0, 0, 0, 5, 3, 1);

        // Month edit clamps day 31 to 28 in year 01
        do_reset();
        pulse(M_YEAR, 1'b1, 1'b0, 1);
        pulse(M_DAY,  1'b0, 1'b1, 1);
        step(1);
        chk("pre_D10", D10, 8'h33);
        chk("pre_D1",  D1,  8'h31);
        pulse(M_MON, 1'b1, 1'b0, 1);
        chk("lag_D1", D1, 8'h31);
        step(1);
        chk("clamp_MT1", MT1, 8'h32);
        chk("clamp_D10", D10, 8'h32);
        chk("clamp_D1",  D1,  8'h38);

        // Minute wrap without carry, UP+DOWN no-op, no ticks while in SET
        do_reset();
        pulse(M_MIN, 1'b0, 1'b1, 1);
        step(1);
        check_all(0, 59, 0, 0, 1, 1);
        pulse(M_MIN, 1'b1, 1'b1, 1);
        step(1);
        chk("both_M10", M10, 8'h35);
        chk("both_M1",  M1,  8'h39);
        tick_seen = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (SEC_TICK !== 1'b0) tick_seen++;
        end
        chk("set_no_tick", 8'(tick_seen), 8'h00);
        check_all(0, 59, 0, 0, 1, 1);

        // Asynchronous reset mid-count, then first tick 4 cycles after release
        do_reset();
        step(6);
        chk("pre_rst_S1", S1, 8'h31);
        RESET = 1'b1;
        #1;
        check_all(0, 0, 0, 0, 1, 1);
        chk("async_tick", {7'b0, SEC_TICK}, 8'h00);
        step(1);
        RESET = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step(1);
            chk("post_rst_tick", {7'b0, SEC_TICK}, (k == 4) ? 8'h01 : 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_calendar_core.md
# time_calendar_core

Timekeeping and calendar stage that sits directly upstream of the LCD display controller. It divides the system clock into a 1 s tick and keeps 24-hour time and a 2000–2099 calendar with leap years. It applies the user's per-field set commands for the current-time control modes. It emits every field as two registered ASCII digit bytes, which the display controller writes straight into its character buffer.

## Interface
- TICK_DIV, 50000: CLK cycles per second; legal range 2..2^20.
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- MODE  in  6  UI mode code, shared with the display controller.
- UP  in  1  single-cycle pulse; increments the selected field.
- DOWN  in  1  single-cycle pulse; decrements the selected field.
- H10, H1, M10, M1, S10, S1  out  8 each  ASCII hour, minute and second digits (0x30–0x39).
- Y10, Y1, MT10, MT1, D10, D1  out  8 each  ASCII year (00–99), month and day digits.
- SEC_TICK  out  1  one-cycle pulse each time the seconds field advances through free running.

## Operation
- Internal binary state:
  - prescaler PCNT, 0..TICK_DIV-1
  - hour 0–23, minute 0–59, second 0–59
  - year 0–99, month 1–12, day 1..DIM
- DIM is the number of days in the month:
  - 31 for months 1, 3, 5, 7, 8, 10, 12
  - 30 for months 4, 6, 9, 11
  - February: 29 when year[1:0]==0, else 28
- MODE decode:
  - 010011 selects hour set.
  - 010101 selects minute set.
  - 010111 selects second set.
  - 011011 selects year set.
  - 011101 selects month set.
  - 011111 selects day set.
  - Any other code is run mode.
- State RUN, when MODE is not a set code:
  - PCNT increments every cycle.
  - When PCNT==TICK_DIV-1: PCNT goes to 0, SEC_TICK=1, and second increments.
  - Carry chain: second 59→0 carries to minute, minute 59→0 carries to hour, hour 23→0 carries to day.
  - Day DIM→1 carries to month, month 12→1 carries to year, year 99→0.
  - UP and DOWN are ignored.
- State SET, when MODE is a set code:
  - PCNT is held at 0 and SEC_TICK stays 0. Time is frozen.
  - UP increments the selected field with wrap inside its own range and no carry. Example: minute 59→0 leaves the hour unchanged.
  - DOWN decrements the selected field with the same wrap. Examples: second 0→59, month 1→12, day 1→DIM, year 0→99.
  - UP and DOWN asserted in the same cycle: no change.
  - After a month or year change, if day exceeds the new DIM, day is clamped to DIM in the same edge.
- Transitions:
  - RUN→SET takes effect on the first edge where MODE decodes as set. PCNT clears on that edge.
  - SET→RUN: counting restarts from PCNT=0.
- Output conversion: tens and units = field/10 and field%10, each added to 0x30.

## Timing
- Reset values, asynchronous:
  - PCNT=0, SEC_TICK=0
  - 00:00:00, year 0, month 1, day 1
  - Outputs are all 0x30 except MT1=0x31 and D1=0x31.
- Binary fields update on the edge where PCNT==TICK_DIV-1, or on the edge where UP/DOWN is sampled.
- The ASCII outputs are registered and lag the binary state by exactly 1 cycle.
- SEC_TICK is registered and is high during the same cycle the new seconds are visible on the binary state. It precedes the S1 change by 1 cycle.
- UP/DOWN are sampled every edge; each high cycle is one step. A pulse 3 cycles wide gives 3 steps.
- Reset asserted mid-count or mid-set aborts immediately. All state returns to the reset values with no partial carry.
- The first tick after reset release occurs TICK_DIV cycles later.

## Test plan
All scenarios use TICK_DIV=4.
- Reset, then 12 cycles in MODE=000000 -> SEC_TICK pulses at cycles 4, 8 and 12. S1 reads 0x31, 0x32, 0x33, each one cycle after the corresponding pulse. All other digits stay at their reset values.
- Preset 23:59:59 on 99-12-31 via set modes, then RUN for 4 cycles -> outputs read 00:00:00 on 00-01-01 (Y10/Y1=0x30, MT=0x30/0x31, D=0x30/0x31).
- Leap rollover: year 04, 02-28 23:59:59, then one tick -> day 29. Year 05 under the same conditions -> 03-01.
- Set clamp: day 31 in month 01, MODE=011101, UP -> month 02. With year 01, day is clamped to 28 (D10=0x32, D1=0x38) one cycle later.
- Set wrap: MODE=010101 at minute 0, DOWN -> minute 59 with hour unchanged. UP and DOWN together -> no change. SEC_TICK stays 0 for 20 cycles in SET.
- Assert RESET at PCNT=2 during RUN -> outputs return to reset values immediately. After release, the first SEC_TICK comes 4 cycles later.
